// File: rtl/game_pkg.sv
// Shared types and constants for the Conway run-control sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    S_LOAD,
    S_PAUSED,
    S_RUN,
    S_CHECK,
    S_HALT
  } seq_state_t;

  localparam logic [1:0] SPEED_SLOW = 2'd0;
  localparam logic [1:0] SPEED_MED  = 2'd1;
  localparam logic [1:0] SPEED_FAST = 2'd2;
  localparam logic [1:0] SPEED_MAX  = 2'd3;

  // Each speed step divides the step period by four.
  function automatic logic [2:0] speed_shift(input logic [1:0] speed);
    return {speed, 1'b0};
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button -> 2-flop sync -> debounce (stable 2^DEBOUNCE_W samples) -> one-cycle press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic                  sync1;
  logic                  sync2;
  logic                  stable;
  logic [DEBOUNCE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      // Any bounce back to the accepted level restarts the stability window.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        stable <= sync2;
        cnt    <= '0;
        pulse  <= sync2;
      end else begin
        cnt <= cnt + DEBOUNCE_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Run/pause/single-step scheduler driving cell ena/load strobes, with generation count and auto-halt.
// Define STAGNATION_DETECT_EN to also halt when a step leaves the grid unchanged (still life).
module game_sequencer
  import game_pkg::*;
#(
  parameter int N           = 8,
  parameter int BASE_PERIOD = 8388608,
  parameter int DEBOUNCE_W  = 16,
  parameter int GEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_load,
  input  logic [1:0]       speed,
  input  logic [N*N-1:0]   cells_q,
  output logic             cell_ena,
  output logic             cell_load,
  output logic             running,
  output logic             halted,
  output logic [GEN_W-1:0] generation
);

  localparam int DIV_W = $clog2(BASE_PERIOD) + 1;

  logic run_p, step_p, load_p;

  button_conditioner #(.DEBOUNCE_W(DEBOUNCE_W)) u_run (
    .clk(clk), .rst(rst), .btn(btn_run), .pulse(run_p)
  );
  button_conditioner #(.DEBOUNCE_W(DEBOUNCE_W)) u_step (
    .clk(clk), .rst(rst), .btn(btn_step), .pulse(step_p)
  );
  button_conditioner #(.DEBOUNCE_W(DEBOUNCE_W)) u_load (
    .clk(clk), .rst(rst), .btn(btn_load), .pulse(load_p)
  );

  seq_state_t       state, state_nxt;
  logic             from_run, from_run_nxt;
  logic [DIV_W-1:0] divider, divider_nxt;
  logic [DIV_W-1:0] period;
  logic [GEN_W-1:0] gen_nxt;
  logic             step_due;
  logic             stuck;
  logic             halt_cond;

  // Compare against the live period so a speed change takes effect at once.
  assign period    = DIV_W'(BASE_PERIOD) >> speed_shift(speed);
  assign step_due  = (divider >= (period - DIV_W'(1)));
  assign halt_cond = (cells_q == '0) || stuck;

`ifdef STAGNATION_DETECT_EN
  logic [N*N-1:0] snapshot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot <= '0;
    end else if (state == S_LOAD) begin
      snapshot <= '0;
    end else if (cell_ena) begin
      snapshot <= cells_q;
    end
  end

  assign stuck = (cells_q == snapshot);
`else
  assign stuck = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_LOAD;
      from_run   <= 1'b0;
      divider    <= '0;
      generation <= '0;
    end else begin
      state      <= state_nxt;
      from_run   <= from_run_nxt;
      divider    <= divider_nxt;
      generation <= gen_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    from_run_nxt = from_run;
    divider_nxt  = divider;
    gen_nxt      = generation;
    cell_ena     = 1'b0;
    cell_load    = 1'b0;
    case (state)
      S_LOAD: begin
        cell_load    = 1'b1;
        gen_nxt      = '0;
        divider_nxt  = '0;
        from_run_nxt = 1'b0;
        state_nxt    = S_PAUSED;
      end
      S_PAUSED: begin
        if (load_p) begin
          state_nxt = S_LOAD;
        end else if (run_p) begin
          divider_nxt = '0;
          state_nxt   = S_RUN;
        end else if (step_p) begin
          cell_ena     = 1'b1;
          from_run_nxt = 1'b0;
          state_nxt    = S_CHECK;
        end
      end
      S_RUN: begin
        if (load_p) begin
          state_nxt = S_LOAD;
        end else if (run_p) begin
          state_nxt = S_PAUSED;
        end else if (step_due) begin
          cell_ena     = 1'b1;
          divider_nxt  = '0;
          from_run_nxt = 1'b1;
          state_nxt    = S_CHECK;
        end else begin
          divider_nxt = divider + DIV_W'(1);
        end
      end
      S_CHECK: begin
        if (generation != '1) gen_nxt = generation + GEN_W'(1);
        // A run press landing here flips the return destination.
        if (run_p) from_run_nxt = ~from_run;
        if (load_p) begin
          state_nxt = S_LOAD;
        end else if (halt_cond) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = (from_run ^ run_p) ? S_RUN : S_PAUSED;
        end
      end
      S_HALT: begin
        if (load_p) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  assign running = (state == S_RUN) || ((state == S_CHECK) && from_run);
  assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench: stimulus queues expected strobes, a negedge monitor pops and compares them.
module tb_game_sequencer;

  localparam int N     = 4;
  localparam int GEN_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              btn_run, btn_step, btn_load;
  logic [1:0]        speed;
  logic [N*N-1:0]    cells_q;
  logic              cell_ena, cell_load, running, halted;
  logic [GEN_W-1:0]  generation;

  game_sequencer #(.N(N), .BASE_PERIOD(64), .DEBOUNCE_W(2), .GEN_W(GEN_W)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .btn_load(btn_load),
    .speed(speed), .cells_q(cells_q), .cell_ena(cell_ena), .cell_load(cell_load),
    .running(running), .halted(halted), .generation(generation)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_load;
    int gap;   // cycles since previous strobe, -1 = don't care
    int gen;   // generation seen during the strobe, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input bit is_load, input int gap, input int gen);
    exp_t e;
    e.is_load = is_load;
    e.gap     = gap;
    e.gen     = gen;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      if (cell_ena || cell_load) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", int'({cell_ena, cell_load}), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_kind_load", int'(cell_load), int'(e.is_load));
          check("strobe_exclusive", int'(cell_ena & cell_load), 0);
          if (e.gap >= 0) check("strobe_gap", cyc - last_cyc, e.gap);
          if (e.gen >= 0) check("strobe_generation", int'(generation), e.gen);
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic r, input logic s, input logic l, input int hold);
    btn_run  = r;
    btn_step = s;
    btn_load = l;
    step_cycles(hold);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    btn_load = 1'b0;
    step_cycles(10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_load = 1'b0;
    speed = 2'd0; cells_q = 16'h0660;
    step_cycles(3);
    check("reset_cell_load", int'(cell_load), 1);
    check("reset_cell_ena", int'(cell_ena), 0);
    check("reset_generation", int'(generation), 0);
    check("reset_running", int'(running), 0);
    check("reset_halted", int'(halted), 0);

    // Reset release: one load strobe, then paused and quiet.
    push(1'b1, -1, 0);
    rst = 1'b1;
    step_cycles(200);
    check("idle_generation", int'(generation), 0);
    check("idle_running", int'(running), 0);
    check("idle_halted", int'(halted), 0);

    // Single step while paused.
    push(1'b0, -1, 0);
    press(1'b0, 1'b1, 1'b0, 10);
    step_cycles(20);
    check("step_generation", int'(generation), 1);
    check("step_running", int'(running), 0);
    check("step_halted", int'(halted), 0);

    // Run at speed 0: one step per 65 cycles.
    push(1'b0, -1, 1);
    push(1'b0, 65, 2);
    push(1'b0, 65, 3);
    press(1'b1, 1'b0, 1'b0, 10);
    check("run_running", int'(running), 1);
    step_cycles(190);

    // Speed 3 mid-count: divider already past period-1, fires now, then every 2 cycles.
    push(1'b0, -1, 4);
    for (int i = 1; i <= 10; i++) push(1'b0, 2, 4 + i);
    speed = 2'd3;
    step_cycles(20);
    cells_q = '0;
    step_cycles(10);
    check("extinct_halted", int'(halted), 1);
    check("extinct_running", int'(running), 0);
    check("extinct_generation", int'(generation), 15);
    step_cycles(100);

    // Run/step presses are ignored while halted.
    press(1'b1, 1'b1, 1'b0, 10);
    check("halt_ignores_halted", int'(halted), 1);
    check("halt_ignores_generation", int'(generation), 15);

    // Load leaves HALT.
    cells_q = 16'h0660;
    speed   = 2'd0;
    push(1'b1, -1, 15);
    press(1'b0, 1'b0, 1'b1, 10);
    check("load_generation", int'(generation), 0);
    check("load_halted", int'(halted), 0);
    check("load_running", int'(running), 0);

    // One-cycle glitch on run is filtered out.
    btn_run = 1'b1;
    step_cycles(1);
    btn_run = 1'b0;
    step_cycles(20);
    check("glitch_running", int'(running), 0);

    // Run + step together: toggle only, no single step; then pause before any step.
    press(1'b1, 1'b1, 1'b0, 10);
    check("runstep_running", int'(running), 1);
    check("runstep_generation", int'(generation), 0);
    press(1'b1, 1'b0, 1'b0, 10);
    check("pause_running", int'(running), 0);

    // Step with an unchanged grid.
    push(1'b0, -1, 0);
    press(1'b0, 1'b1, 1'b0, 10);
    check("stagnant_generation", int'(generation), 1);
`ifdef STAGNATION_DETECT_EN
    check("stagnant_halted", int'(halted), 1);
`else
    check("stagnant_halted", int'(halted), 0);
    push(1'b0, -1, 1);
    press(1'b0, 1'b1, 1'b0, 10);
    check("stagnant_generation2", int'(generation), 2);
    check("stagnant_halted2", int'(halted), 0);
`endif

    step_cycles(50);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
